spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: host-request driven SPI master framing 10-bit {cmd, data}
// frames MSB first, with an optional turnaround + 8-bit read phase for
// read-data commands.
// Optional feature macro: SPI_MASTER_CTRL_ERR_CHECK_EN rejects a read-data
// request (cmd 11) when no read-address frame has completed since the last
// read-data frame.
module spi_master_ctrl #(
   parameter int unsigned TURN_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_cmd,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       err,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   typedef enum logic [2:0] {
      IDLE, START, SHIFT, TURN, READ, STOP, ERR
   } state_t;

   localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic [9:0] frame, frame_nx;
   logic [1:0] cmd, cmd_nx;
   logic [7:0] cap, cap_nx;
   logic [7:0] rsp_data_nx;
   logic       addr_ok, addr_ok_nx;
   logic       ss_nx, mosi_nx;
   logic       accept, reject;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == STOP);

`ifdef SPI_MASTER_CTRL_ERR_CHECK_EN
   assign reject = (req_cmd == 2'b11) && !addr_ok;
   assign err    = (state == ERR);
`else
   assign reject = 1'b0;
   assign err    = 1'b0;
`endif

   // Next-state and next-output logic; SS_n/MOSI are computed one cycle ahead
   // so that the registered pins line up with the state they belong to.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      frame_nx    = frame;
      cmd_nx      = cmd;
      cap_nx      = cap;
      rsp_data_nx = rsp_data;
      addr_ok_nx  = addr_ok;
      ss_nx       = 1'b1;
      mosi_nx     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               frame_nx = {req_cmd, req_data};
               cmd_nx   = req_cmd;
               if (reject) begin
                  state_nx = ERR;
               end else begin
                  state_nx = START;
                  ss_nx    = 1'b0;
                  mosi_nx  = req_cmd[1];
               end
            end
         end
         START: begin
            // START repeats cmd[1]; the frame register then shifts so that
            // frame[9] always holds the bit for the following SHIFT cycle.
            state_nx = SHIFT;
            ss_nx    = 1'b0;
            mosi_nx  = frame[9];
            frame_nx = {frame[8:0], 1'b0};
            cnt_nx   = '0;
         end
         SHIFT: begin
            ss_nx = 1'b0;
            if (cnt == 4'd9) begin
               cnt_nx = '0;
               if (cmd == 2'b11) begin
                  state_nx = TURN;
               end else begin
                  state_nx = STOP;
                  ss_nx    = 1'b1;
               end
            end else begin
               cnt_nx   = cnt + 4'd1;
               mosi_nx  = frame[9];
               frame_nx = {frame[8:0], 1'b0};
            end
         end
         TURN: begin
            ss_nx = 1'b0;
            if (cnt == TURN_LAST) begin
               cnt_nx   = '0;
               state_nx = READ;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         READ: begin
            ss_nx  = 1'b0;
            cap_nx = {cap[6:0], MISO};
            if (cnt == 4'd7) begin
               cnt_nx      = '0;
               state_nx    = STOP;
               ss_nx       = 1'b1;
               rsp_data_nx = {cap[6:0], MISO};
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         STOP: begin
            state_nx = IDLE;
            if (cmd == 2'b10) addr_ok_nx = 1'b1;
            if (cmd == 2'b11) addr_ok_nx = 1'b0;
         end
         ERR: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and registered pin update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         frame    <= '0;
         cmd      <= '0;
         cap      <= '0;
         rsp_data <= '0;
         addr_ok  <= 1'b0;
         SS_n     <= 1'b1;
         MOSI     <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         frame    <= frame_nx;
         cmd      <= cmd_nx;
         cap      <= cap_nx;
         rsp_data <= rsp_data_nx;
         addr_ok  <= addr_ok_nx;
         SS_n     <= ss_nx;
         MOSI     <= mosi_nx;
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: directed and random frames checked
// cycle by cycle against a timeline derived from the frame rules.
module tb_spi_master_ctrl;

   localparam int T = 2;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_cmd;
   logic [7:0] req_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       err;
   logic       busy;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [7:0] m_rsp_data = 8'h00;
   logic       m_addr_ok  = 1'b0;

   spi_master_ctrl #(.TURN_CYCLES(T)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_cmd  (req_cmd),
      .req_data (req_data),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .err      (err),
      .busy     (busy),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      req_cmd = 2'b00;
      req_data = 8'h00;
      MISO = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({SS_n, MOSI, rsp_valid, err, busy, req_ready} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=100000 (ss,mosi,rv,err,busy,rdy)",
                  {SS_n, MOSI, rsp_valid, err, busy, req_ready});
      end
      checks++;
      if (rsp_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_rsp_data got=%h exp=00", rsp_data);
      end
      checks++;
      if (dut.addr_ok !== 1'b0) begin
         failures++;
         $display("FAIL reset_addr_ok got=%b exp=0", dut.addr_ok);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got=%b exp=1", req_ready);
      end
      m_rsp_data = 8'h00;
      m_addr_ok  = 1'b0;
   endtask

   // One complete request, checked every cycle from accept to the idle cycle.
   task automatic test_frame(input logic [1:0] cmd, input logic [7:0] data,
                             input logic [7:0] rbyte);
      logic [9:0] fr;
      logic       is_err;
      int         stop;
      logic       exp_ss, exp_mosi;
      logic [4:0] exp_v, got_v;
      logic [7:0] exp_rd;
      fr = {cmd, data};
      is_err = 1'b0;
`ifdef SPI_MASTER_CTRL_ERR_CHECK_EN
      is_err = (cmd == 2'b11) && !m_addr_ok;
`endif
      stop = is_err ? 1 : ((cmd == 2'b11) ? 12 + T + 8 : 12);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL frame_ready_c0 got=%b exp=1", req_ready);
      end
      req_valid = 1'b1;
      req_cmd = cmd;
      req_data = data;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_cmd = 2'($urandom);
      req_data = 8'($urandom);
      for (int c = 1; c <= stop; c++) begin
         @(negedge clk);
         exp_ss = is_err || (c == stop);
         exp_mosi = 1'b0;
         if (!is_err && c == 1) exp_mosi = cmd[1];
         else if (!is_err && c >= 2 && c <= 11) exp_mosi = fr[11 - c];
         exp_v = {exp_ss, exp_mosi, 1'b1, (!is_err && c == stop), (is_err && c == 1)};
         got_v = {SS_n, MOSI, busy, rsp_valid, err};
         if (c == stop && !is_err) begin
            if (cmd == 2'b11) m_rsp_data = rbyte;
            if (cmd == 2'b10) m_addr_ok = 1'b1;
            if (cmd == 2'b11) m_addr_ok = 1'b0;
         end
         exp_rd = m_rsp_data;
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL frame_pins cmd=%b c=%0d got=%b exp=%b (ss,mosi,busy,rv,err)",
                     cmd, c, got_v, exp_v);
         end
         checks++;
         if (rsp_data !== exp_rd) begin
            failures++;
            $display("FAIL frame_rsp_data cmd=%b c=%0d got=%h exp=%h", cmd, c, rsp_data, exp_rd);
         end
         if (!is_err && cmd == 2'b11 && c >= 12 + T && c < 12 + T + 8)
            MISO = rbyte[7 - (c - 12 - T)];
         else
            MISO = 1'($urandom);
      end
      @(negedge clk);
      checks++;
      if ({SS_n, MOSI, busy, rsp_valid, err, req_ready} !== 6'b100001) begin
         failures++;
         $display("FAIL frame_idle cmd=%b got=%b exp=100001 (ss,mosi,busy,rv,err,rdy)",
                  cmd, {SS_n, MOSI, busy, rsp_valid, err, req_ready});
      end
      checks++;
      if (dut.addr_ok !== m_addr_ok) begin
         failures++;
         $display("FAIL frame_addr_ok cmd=%b got=%b exp=%b", cmd, dut.addr_ok, m_addr_ok);
      end
   endtask

   task automatic test_directed();
      test_frame(2'b00, 8'h3C, 8'h00);
      test_frame(2'b10, 8'h10, 8'h00);
      test_frame(2'b11, 8'h00, 8'hA5);
      test_frame(2'b01, 8'h81, 8'h00);
   endtask

   task automatic test_back_to_back();
      logic [9:0] fr1, fr2;
      logic       exp_mosi;
      logic [3:0] exp_v, got_v;
      fr1 = {2'b01, 8'h55};
      fr2 = {2'b01, 8'hAA};
      req_valid = 1'b1;
      req_cmd = 2'b01;
      req_data = 8'h55;
      @(posedge clk);
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         exp_mosi = 1'b0;
         if (c >= 2 && c <= 11) exp_mosi = fr1[11 - c];
         else if (c >= 15 && c <= 24) exp_mosi = fr2[24 - c];
         exp_v = {(c == 12 || c == 13 || c >= 25), exp_mosi,
                  (c == 12 || c == 25), (c == 13 || c == 26)};
         got_v = {SS_n, MOSI, rsp_valid, req_ready};
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL b2b_pins c=%0d got=%b exp=%b (ss,mosi,rv,rdy)", c, got_v, exp_v);
         end
         if (c == 1) req_data = 8'hAA;
         if (c == 14) req_valid = 1'b0;
      end
   endtask

   task automatic test_reset_midframe();
      req_valid = 1'b1;
      req_cmd = 2'b01;
      req_data = 8'($urandom);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++;
         if (SS_n !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ss c=%0d got=%b exp=0", c, SS_n);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({SS_n, MOSI, busy, rsp_valid, req_ready} !== 5'b10000) begin
         failures++;
         $display("FAIL midrst_abort got=%b exp=10000 (ss,mosi,busy,rv,rdy)",
                  {SS_n, MOSI, busy, rsp_valid, req_ready});
      end
      checks++;
      if (rsp_data !== 8'h00) begin
         failures++;
         $display("FAIL midrst_rsp_data got=%h exp=00", rsp_data);
      end
      m_rsp_data = 8'h00;
      m_addr_ok  = 1'b0;
      rst = 1'b0;
      #1;
      test_frame(2'b00, 8'($urandom), 8'h00);
   endtask

   task automatic test_random();
      logic [1:0] cmd;
      for (int i = 0; i < 24; i++) begin
         cmd = 2'($urandom_range(0, 3));
         test_frame(cmd, 8'($urandom), 8'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         #1;
      end
   endtask

   task automatic test_read_without_addr();
      // after reset addr_ok is clear; a read-data request either errors or frames
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_rsp_data = 8'h00;
      m_addr_ok  = 1'b0;
      #1;
      test_frame(2'b11, 8'h00, 8'h3E);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midframe();
      test_read_without_addr();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
